alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational ALU between two requesters (e.g. execute-stage issue and address-generation issue).
- Arbitrates round-robin and drives the ALU operand and opcode inputs from registered copies of the granted request.
- Captures the ALU result and psw, and returns them on a valid/ready response channel tagged with the requester id.
- Sits between the issue logic and the ALU instance; the ALU itself is unchanged.

Parameters:
- DATA_W, 32, operand/result width
- OP_W, 4, ALU opcode width (0000 add, 0001 sub, 1000 not-A; other codes passed through untouched)
- PSW_W, 4, ALU status-word width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- req0_valid  in  1  requester 0 has an op
- req0_ready  out  1  requester 0 op accepted this cycle
- req0_a  in  DATA_W  operand A
- req0_b  in  DATA_W  operand B
- req0_op  in  OP_W  opcode
- req1_valid, req1_ready, req1_a, req1_b, req1_op  same as requester 0, for requester 1
- alu_a  out  DATA_W  to ALU operandA
- alu_b  out  DATA_W  to ALU operandB
- alu_op  out  OP_W  to ALU opcode
- alu_result  in  DATA_W  from ALU result
- alu_psw  in  PSW_W  from ALU psw
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  DATA_W  captured result
- rsp_psw  out  PSW_W  captured psw
- rsp_id  out  1  requester that issued the op
- busy  out  1  high whenever state is not IDLE

Behaviour:
- FSM states: IDLE, EXEC, RESP. All state changes occur on rising clk.
- Reset (rst high at an edge):
  - state=IDLE, priority pointer=0 (requester 0 favoured)
  - operand, opcode and id registers=0, so alu_a/alu_b/alu_op=0
  - rsp_valid=0, rsp_result=0, rsp_psw=0, rsp_id=0, busy=0
  - reqN_ready=0 while rst is high
- IDLE, grant:
  - Grant is combinational. If only one reqN_valid is high, that requester is granted. If both are high, the requester named by the pointer is granted.
  - reqN_ready=1 only for the granted requester, only in IDLE, and only when rst is low.
  - On the accept edge: latch a, b, op and id; set the pointer to the non-granted requester; move to EXEC.
  - If no request is valid, stay in IDLE and leave the pointer unchanged.
- EXEC (exactly one cycle):
  - alu_a/alu_b/alu_op come from the latched registers. They are stable for the whole cycle and are never taken combinationally from req inputs.
  - At the end of the cycle, capture alu_result into rsp_result and alu_psw into rsp_psw, set rsp_valid=1 and move to RESP.
- RESP:
  - rsp_valid stays 1 and rsp_result/rsp_psw/rsp_id are held constant until rsp_ready=1.
  - On the handshake edge: rsp_valid=0, move to IDLE. The next accept happens no earlier than the following cycle.
  - No request is accepted while in EXEC or RESP.
- Latency and throughput:
  - Accept at edge N (req ready & valid). EXEC runs during cycle N+1. rsp_valid rises after edge N+1, visible in cycle N+2.
  - With rsp_ready tied high: one op per 3 cycles.
- ALU outputs hold the last latched values outside EXEC. This avoids toggling the ALU needlessly; downstream logic must not rely on values outside EXEC.
- Requester rule: a requester holds valid/a/b/op stable until it sees ready. The arbiter does not check this; dropping valid early simply withdraws the request.
- Simultaneous events:
  - Both valid with pointer=1 → requester 1 wins.
  - rsp_ready high in EXEC has no effect, because rsp_valid is still 0.
- Reset mid-operation (EXEC or RESP): the in-flight op is discarded, no response is produced and all state returns to reset values.
- Width: operands, results and psw are passed through unmodified. There is no sign extension or truncation inside the arbiter.

Test Plan:
1. Reset, then req0 add (a=0x0000006B, b=0x00000005, op=0000) → req0_ready high for one cycle; rsp_valid in accept+2 with rsp_result=0x00000070, rsp_id=0.
2. Both valid in the same cycle after reset: req0 sub (0x6B, 0x05, op=0001) and req1 not (a=0x01101011, op=1000) → req0 served first (result 0x00000066, id 0), then req1 (result 0xFEEFEFEE, id 1). req1_ready stays low until the first response handshakes.
3. Backpressure: hold rsp_ready=0 for 5 cycles in RESP → rsp_* stable, busy=1, both readies 0. When rsp_ready rises, exactly one response is consumed, and busy=0 the next cycle.
4. Fairness: both requesters hold valid for 6 consecutive ops, rsp_ready=1 → rsp_id sequence 0,1,0,1,0,1; each op spaced exactly 3 cycles apart.
5. Assert rst for one cycle while in EXEC → following cycle rsp_valid=0, busy=0, alu_a/alu_b/alu_op=0. No response ever appears for the killed op, and the next simultaneous request pair is granted to req0.
6. Psw capture: ALU model drives alu_psw=4'b1010 during EXEC and changes it afterwards → rsp_psw stays 4'b1010 throughout RESP.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one combinational ALU between two requesters with
// round-robin grant, registered ALU operands and a valid/ready response channel.
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4,
  parameter int PSW_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0]   req1_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [PSW_W-1:0]  alu_psw,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [PSW_W-1:0]  rsp_psw,
  output logic              rsp_id,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               ptr_q, ptr_d;
  logic [DATA_W-1:0]  a_q, a_d;
  logic [DATA_W-1:0]  b_q, b_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic               id_q, id_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_result_q, rsp_result_d;
  logic [PSW_W-1:0]   rsp_psw_q, rsp_psw_d;
  logic               grant_s;
  logic               accept_s;

  // Grant: a lone requester wins; on a tie the pointer names the winner.
  always_comb begin
    grant_s  = 1'b0;
    accept_s = 1'b0;
    if ((state_q == IDLE) && !rst) begin
      if (req0_valid && req1_valid) begin
        grant_s  = ptr_q;
        accept_s = 1'b1;
      end else if (req0_valid) begin
        grant_s  = 1'b0;
        accept_s = 1'b1;
      end else if (req1_valid) begin
        grant_s  = 1'b1;
        accept_s = 1'b1;
      end else begin
        grant_s  = 1'b0;
        accept_s = 1'b0;
      end
    end else begin
      grant_s  = 1'b0;
      accept_s = 1'b0;
    end
  end

  assign req0_ready = accept_s & ~grant_s;
  assign req1_ready = accept_s & grant_s;

  // Next state: latch the winner in IDLE, capture the ALU in EXEC, hold in RESP.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_psw_d    = rsp_psw_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          a_d     = grant_s ? req1_a  : req0_a;
          b_d     = grant_s ? req1_b  : req0_b;
          op_d    = grant_s ? req1_op : req0_op;
          id_d    = grant_s;
          ptr_d   = ~grant_s;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        rsp_result_d = alu_result;
        rsp_psw_d    = alu_psw;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset discards any in-flight op.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ptr_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_psw_q    <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_psw_q    <= rsp_psw_d;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_psw    = rsp_psw_q;
  assign rsp_id     = id_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench for alu_share_arbiter: directed scenarios plus a random
// run checked against a transaction-level model of grant order and responses.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
  logic [3:0]  req0_op = 4'd0, req1_op = 4'd0;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_op, alu_psw;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_psw;
  logic        rsp_id, busy;
  logic        psw_force_en = 1'b0;
  logic [3:0]  psw_force = 4'd0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    case (op)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b1000: return ~a;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [3:0] ref_psw(input logic [31:0] r);
    return {r[31], (r == 32'd0), r[0], 1'b1};
  endfunction

  function automatic logic [3:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return 4'b0000;
      1:       return 4'b0001;
      2:       return 4'b1000;
      default: return 4'($urandom_range(0, 15));
    endcase
  endfunction

  // Stand-in for the shared ALU; psw can be forced to probe capture timing.
  assign alu_result = ref_alu(alu_a, alu_b, alu_op);
  assign alu_psw    = psw_force_en ? psw_force : ref_psw(alu_result);

  alu_share_arbiter #(.DATA_W(32), .OP_W(4), .PSW_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result), .alu_psw(alu_psw),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_psw(rsp_psw),
    .rsp_id(rsp_id), .busy(busy)
  );

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b want 0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1: got %b want 0", req1_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    checks++; if ({rsp_result, rsp_psw, rsp_id} !== 37'd0) begin errors++; $display("FAIL reset_rsp: got %h/%h/%b want 0", rsp_result, rsp_psw, rsp_id); end
    checks++; if ({alu_a, alu_b, alu_op} !== 68'd0) begin errors++; $display("FAIL reset_alu: got %h/%h/%h want 0", alu_a, alu_b, alu_op); end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_single_add();
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'h0000006B; req0_b = 32'h00000005; req0_op = 4'b0000;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL add_ready: got %b want 1", req0_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL add_ready_pulse: got %b want 0", req0_ready); end
    checks++; if ({alu_a, alu_b, alu_op} !== {32'h0000006B, 32'h00000005, 4'b0000}) begin errors++; $display("FAIL add_alu_in: got %h/%h/%h", alu_a, alu_b, alu_op); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL add_early_rsp: got %b want 0", rsp_valid); end
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_result, rsp_id} !== {1'b1, 32'h00000070, 1'b0}) begin errors++; $display("FAIL add_rsp: got v=%b r=%h id=%b want v=1 r=00000070 id=0", rsp_valid, rsp_result, rsp_id); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL add_done: got v=%b busy=%b want 0 0", rsp_valid, busy); end
  endtask

  task automatic test_both_valid();
    apply_reset();
    req0_valid = 1'b1; req0_a = 32'h0000006B; req0_b = 32'h00000005; req0_op = 4'b0001;
    req1_valid = 1'b1; req1_a = 32'h01101011; req1_b = $urandom(); req1_op = 4'b1000;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL both_grant0: got %b%b want 10", req0_ready, req1_ready); end
    @(negedge clk);
    req0_valid = 1'b0;
    #1;
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL both_r1_exec: got %b want 0", req1_ready); end
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_result, rsp_id} !== {1'b1, 32'h00000066, 1'b0}) begin errors++; $display("FAIL both_rsp0: got v=%b r=%h id=%b want v=1 r=00000066 id=0", rsp_valid, rsp_result, rsp_id); end
    rsp_ready = 1'b1;
    #1;
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL both_r1_resp: got %b want 0", req1_ready); end
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL both_grant1: got %b want 1", req1_ready); end
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    checks++; if ({rsp_valid, rsp_result, rsp_id} !== {1'b1, 32'hFEEFEFEE, 1'b1}) begin errors++; $display("FAIL both_rsp1: got v=%b r=%h id=%b want v=1 r=feefefee id=1", rsp_valid, rsp_result, rsp_id); end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_res;
    @(negedge clk);
    req0_valid = 1'b1; req0_a = $urandom(); req0_b = $urandom(); req0_op = rand_op();
    exp_res = ref_alu(req0_a, req0_b, req0_op);
    @(negedge clk);
    req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++; if ({rsp_valid, rsp_result, rsp_id, busy} !== {1'b1, exp_res, 1'b0, 1'b1}) begin errors++; $display("FAIL bp_hold%0d: got v=%b r=%h id=%b busy=%b want 1 %h 0 1", i, rsp_valid, rsp_result, rsp_id, busy, exp_res); end
      checks++; if ({req0_ready, req1_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready%0d: got %b%b want 00", i, req0_ready, req1_ready); end
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL bp_release: got v=%b busy=%b want 0 0", rsp_valid, busy); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_single: got %b want 0", rsp_valid); end
  endtask

  task automatic test_fairness();
    logic [31:0] exp_res[$];
    logic        exp_id[$];
    logic        renew0, renew1, id;
    int          n_acc, n_rsp, last_acc;
    apply_reset();
    n_acc = 0; n_rsp = 0; last_acc = 0; renew0 = 1'b1; renew1 = 1'b1;
    rsp_ready = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
    for (int cyc = 0; cyc < 60 && n_rsp < 6; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (renew0) begin req0_a = $urandom(); req0_b = $urandom(); req0_op = rand_op(); renew0 = 1'b0; end
      if (renew1) begin req1_a = $urandom(); req1_b = $urandom(); req1_op = rand_op(); renew1 = 1'b0; end
      if (n_acc == 6) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      if (rsp_valid) begin
        checks++;
        if (exp_res.size() == 0) begin
          errors++; $display("FAIL fair_extra_rsp: got r=%h id=%b want none", rsp_result, rsp_id);
        end else if ({rsp_result, rsp_id} !== {exp_res[0], exp_id[0]}) begin
          errors++; $display("FAIL fair_rsp%0d: got r=%h id=%b want r=%h id=%b", n_rsp, rsp_result, rsp_id, exp_res[0], exp_id[0]);
        end
        if (exp_res.size() != 0) begin void'(exp_res.pop_front()); void'(exp_id.pop_front()); end
        n_rsp++;
      end
      #1;
      if (req0_ready || req1_ready) begin
        id = req1_ready;
        checks++; if (id !== 1'(n_acc % 2)) begin errors++; $display("FAIL fair_order%0d: got id %b want %0d", n_acc, id, n_acc % 2); end
        if (n_acc > 0) begin
          checks++; if (cyc - last_acc != 3) begin errors++; $display("FAIL fair_spacing%0d: got %0d cycles want 3", n_acc, cyc - last_acc); end
        end
        exp_res.push_back(id ? ref_alu(req1_a, req1_b, req1_op) : ref_alu(req0_a, req0_b, req0_op));
        exp_id.push_back(id);
        if (id) renew1 = 1'b1; else renew0 = 1'b1;
        last_acc = cyc; n_acc++;
      end
    end
    checks++; if (n_rsp != 6) begin errors++; $display("FAIL fair_count: got %0d responses want 6", n_rsp); end
    @(negedge clk);
    rsp_ready = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_reset_in_exec();
    @(negedge clk);
    req0_valid = 1'b1; req0_a = 32'h12345678; req0_b = 32'h9ABCDEF0; req0_op = 4'b0001;
    @(negedge clk);
    req0_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL kill_state: got v=%b busy=%b want 0 0", rsp_valid, busy); end
    checks++; if ({alu_a, alu_b, alu_op} !== 68'd0) begin errors++; $display("FAIL kill_alu: got %h/%h/%h want 0", alu_a, alu_b, alu_op); end
    rst = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL kill_no_rsp%0d: got %b want 0", i, rsp_valid); end
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL kill_ptr: got %b%b want 10", req0_ready, req1_ready); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_psw_capture();
    psw_force_en = 1'b1; psw_force = 4'b1010;
    @(negedge clk);
    req1_valid = 1'b1; req1_a = $urandom(); req1_b = $urandom(); req1_op = 4'b0000;
    @(negedge clk);
    req1_valid = 1'b0;
    @(negedge clk);
    psw_force = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({rsp_valid, rsp_psw} !== {1'b1, 4'b1010}) begin errors++; $display("FAIL psw_hold%0d: got v=%b psw=%b want 1 1010", i, rsp_valid, rsp_psw); end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0; psw_force_en = 1'b0;
  endtask

  task automatic test_random();
    logic        inflight, mptr, win, exp_r0, exp_r1, exp_id;
    logic [31:0] exp_a, exp_b, exp_res;
    logic [3:0]  exp_op;
    int          acc_cyc, n_ops;
    apply_reset();
    inflight = 1'b0; mptr = 1'b0; win = 1'b0; exp_id = 1'b0;
    exp_a = 32'd0; exp_b = 32'd0; exp_op = 4'd0; exp_res = 32'd0;
    acc_cyc = 0; n_ops = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc != 0) @(negedge clk);
      if (inflight && (cyc - acc_cyc == 1)) begin
        checks++; if ({alu_a, alu_b, alu_op} !== {exp_a, exp_b, exp_op}) begin errors++; $display("FAIL rnd_alu_in c%0d: got %h/%h/%h want %h/%h/%h", cyc, alu_a, alu_b, alu_op, exp_a, exp_b, exp_op); end
      end
      if (inflight && (cyc - acc_cyc >= 2)) begin
        checks++; if ({rsp_valid, rsp_result, rsp_psw, rsp_id} !== {1'b1, exp_res, ref_psw(exp_res), exp_id}) begin errors++; $display("FAIL rnd_rsp c%0d: got v=%b r=%h p=%h id=%b want 1 %h %h %b", cyc, rsp_valid, rsp_result, rsp_psw, rsp_id, exp_res, ref_psw(exp_res), exp_id); end
      end else begin
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rnd_rsp_valid c%0d: got %b want 0", cyc, rsp_valid); end
      end
      checks++; if (busy !== inflight) begin errors++; $display("FAIL rnd_busy c%0d: got %b want %b", cyc, busy, inflight); end
      if (!req0_valid || $urandom_range(0, 3) == 0) begin
        req0_valid = 1'($urandom_range(0, 1)); req0_a = $urandom(); req0_b = $urandom(); req0_op = rand_op();
      end
      if (!req1_valid || $urandom_range(0, 3) == 0) begin
        req1_valid = 1'($urandom_range(0, 1)); req1_a = $urandom(); req1_b = $urandom(); req1_op = rand_op();
      end
      rsp_ready = 1'($urandom_range(0, 1));
      #1;
      exp_r0 = 1'b0; exp_r1 = 1'b0;
      if (!inflight && (req0_valid || req1_valid)) begin
        win = (req0_valid && req1_valid) ? mptr : req1_valid;
        exp_r0 = ~win; exp_r1 = win;
      end
      checks++; if ({req0_ready, req1_ready} !== {exp_r0, exp_r1}) begin errors++; $display("FAIL rnd_ready c%0d: got %b%b want %b%b", cyc, req0_ready, req1_ready, exp_r0, exp_r1); end
      if (exp_r0 || exp_r1) begin
        exp_id  = win;
        exp_a   = win ? req1_a : req0_a;
        exp_b   = win ? req1_b : req0_b;
        exp_op  = win ? req1_op : req0_op;
        exp_res = ref_alu(exp_a, exp_b, exp_op);
        mptr = ~win; inflight = 1'b1; acc_cyc = cyc; n_ops++;
      end else if (inflight && (cyc - acc_cyc >= 2) && rsp_ready) begin
        inflight = 1'b0;
      end
    end
    checks++; if (n_ops < 40) begin errors++; $display("FAIL rnd_throughput: got %0d ops want at least 40", n_ops); end
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    repeat (4) @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_both_valid();
    test_backpressure();
    test_fairness();
    test_reset_in_exec();
    test_psw_capture();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
